// File: rtl/ps2_mouse_pkg.sv
// Shared PS/2 mouse definitions: status-byte bit positions, tracker state
// encoding and the colour written when erasing.
package ps2_mouse_pkg;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XO    = 6;
  localparam int YO    = 7;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_REQ  = 2'd2;

  localparam logic [7:0] ERASE_COLOR = 8'h00;

endpackage

// File: rtl/ps2_cursor_tracker_if.sv
// Packet-in and pixel-write-out handshakes of the cursor tracker.
interface ps2_cursor_tracker_if #(parameter int CW = 10);

  logic          iPKT_VALID;
  logic [7:0]    iPKT_B0;
  logic [7:0]    iPKT_DX;
  logic [7:0]    iPKT_DY;
  logic          oPKT_READY;
  logic          oWR_REQ;
  logic [CW-1:0] oWR_X;
  logic [CW-1:0] oWR_Y;
  logic [7:0]    oWR_DATA;
  logic          iWR_ACK;

  modport slave (
    input  iPKT_VALID, iPKT_B0, iPKT_DX, iPKT_DY, iWR_ACK,
    output oPKT_READY, oWR_REQ, oWR_X, oWR_Y, oWR_DATA
  );

  modport master (
    output iPKT_VALID, iPKT_B0, iPKT_DX, iPKT_DY, iWR_ACK,
    input  oPKT_READY, oWR_REQ, oWR_X, oWR_Y, oWR_DATA
  );

endinterface

// File: rtl/ps2_axis_clamp.sv
// One cursor axis: pos + delta clamped into 0..limit, purely combinational.
module ps2_axis_clamp #(
  parameter int CW = 10
) (
  input  logic [CW-1:0]        i_pos,
  input  logic signed [CW+1:0] i_delta,
  input  logic [CW-1:0]        i_limit,
  output logic [CW-1:0]        o_pos
);

  logic signed [CW+1:0] w_sum;

  // Two extra bits keep pos+delta from wrapping for any 9-bit delta.
  assign w_sum = $signed({2'b00, i_pos}) + i_delta;

  always_comb begin
    o_pos = w_sum[CW-1:0];
    if (w_sum < 0)
      o_pos = '0;
    else if (w_sum > $signed({2'b00, i_limit}))
      o_pos = i_limit;
  end

endmodule

// File: rtl/ps2_cursor_tracker.sv
// Turns PS/2 mouse packets into a clamped absolute cursor and issues
// paint/erase pixel writes while a button is held.
//
// state | meaning
// IDLE  | ready for a packet
// CALC  | apply the latched packet to the cursor
// REQ   | pixel write pending until iWR_ACK
module ps2_cursor_tracker
  import ps2_mouse_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int CW    = 10
) (
  input  logic                 iCLK_50,
  input  logic                 iRST_n,
  ps2_cursor_tracker_if.slave  bus,
  input  logic [7:0]           iCOLOR,
  output logic [CW-1:0]        oCUR_X,
  output logic [CW-1:0]        oCUR_Y,
  output logic [2:0]           oBUTTONS,
  output logic [7:0]           oDROP_CNT
);

  localparam logic [CW-1:0] X_MAX = CW'(H_RES - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(V_RES - 1);
  localparam logic [CW-1:0] X_RST = CW'(H_RES / 2);
  localparam logic [CW-1:0] Y_RST = CW'(V_RES / 2);

  state_t               r_state;
  logic signed [CW+1:0] r_dx;
  logic signed [CW+1:0] r_dy;
  logic [2:0]           r_btn;
  logic [CW-1:0]        r_cur_x;
  logic [CW-1:0]        r_cur_y;
  logic [2:0]           r_buttons;
  logic                 r_wr_req;
  logic [CW-1:0]        r_wr_x;
  logic [CW-1:0]        r_wr_y;
  logic [7:0]           r_wr_data;
  logic [7:0]           r_drop_cnt;

  logic                 w_accept;
  logic                 w_drop;
  logic                 w_paint;
  logic signed [CW+1:0] w_dx_in;
  logic signed [CW+1:0] w_dy_in;
  logic signed [CW+1:0] w_dy_neg;
  logic [CW-1:0]        w_new_x;
  logic [CW-1:0]        w_new_y;

  assign w_accept = bus.iPKT_VALID && (r_state == ST_IDLE) && bus.iPKT_B0[SYNC];
  assign w_drop   = bus.iPKT_VALID && !w_accept;
  assign w_paint  = r_btn[BTN_L] | r_btn[BTN_R];

  // Overflowed axes are discarded rather than trusted as a huge move.
  assign w_dx_in = bus.iPKT_B0[XO] ? '0 : {{(CW-6){bus.iPKT_B0[XS]}}, bus.iPKT_DX};
  assign w_dy_in = bus.iPKT_B0[YO] ? '0 : {{(CW-6){bus.iPKT_B0[YS]}}, bus.iPKT_DY};
  assign w_dy_neg = -r_dy;

  ps2_axis_clamp #(.CW(CW)) u_clamp_x (
    .i_pos   (r_cur_x),
    .i_delta (r_dx),
    .i_limit (X_MAX),
    .o_pos   (w_new_x)
  );

  ps2_axis_clamp #(.CW(CW)) u_clamp_y (
    .i_pos   (r_cur_y),
    .i_delta (w_dy_neg),
    .i_limit (Y_MAX),
    .o_pos   (w_new_y)
  );

  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state    <= ST_IDLE;
      r_dx       <= '0;
      r_dy       <= '0;
      r_btn      <= '0;
      r_cur_x    <= X_RST;
      r_cur_y    <= Y_RST;
      r_buttons  <= '0;
      r_wr_req   <= 1'b0;
      r_wr_x     <= '0;
      r_wr_y     <= '0;
      r_wr_data  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_dx    <= w_dx_in;
            r_dy    <= w_dy_in;
            r_btn   <= {bus.iPKT_B0[BTN_M], bus.iPKT_B0[BTN_R], bus.iPKT_B0[BTN_L]};
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_cur_x   <= w_new_x;
          r_cur_y   <= w_new_y;
          r_buttons <= r_btn;
          if (w_paint) begin
            r_wr_req  <= 1'b1;
            r_wr_x    <= w_new_x;
            r_wr_y    <= w_new_y;
            r_wr_data <= r_btn[BTN_L] ? iCOLOR : ERASE_COLOR;
            r_state   <= ST_REQ;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus.iWR_ACK) begin
            r_wr_req <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.oPKT_READY = (r_state == ST_IDLE);
  assign bus.oWR_REQ    = r_wr_req;
  assign bus.oWR_X      = r_wr_x;
  assign bus.oWR_Y      = r_wr_y;
  assign bus.oWR_DATA   = r_wr_data;
  assign oCUR_X         = r_cur_x;
  assign oCUR_Y         = r_cur_y;
  assign oBUTTONS       = r_buttons;
  assign oDROP_CNT      = r_drop_cnt;

endmodule

// File: tb/tb_ps2_cursor_tracker.sv
// Directed checks of the cursor tracker: movement, clamping, paint/erase
// requests, packet drops and asynchronous reset.
module tb_ps2_cursor_tracker;

  logic       iCLK_50 = 1'b0;
  logic       iRST_n  = 1'b0;
  logic [7:0] iCOLOR  = 8'h00;
  logic [9:0] oCUR_X;
  logic [9:0] oCUR_Y;
  logic [2:0] oBUTTONS;
  logic [7:0] oDROP_CNT;

  int total = 0;
  int bad   = 0;

  ps2_cursor_tracker_if #(.CW(10)) bus ();

  ps2_cursor_tracker #(.H_RES(640), .V_RES(480), .CW(10)) dut (
    .iCLK_50   (iCLK_50),
    .iRST_n    (iRST_n),
    .bus       (bus),
    .iCOLOR    (iCOLOR),
    .oCUR_X    (oCUR_X),
    .oCUR_Y    (oCUR_Y),
    .oBUTTONS  (oBUTTONS),
    .oDROP_CNT (oDROP_CNT)
  );

  always #10 iCLK_50 = ~iCLK_50;

  // Strobe drives just after edge N; outputs are sampled just after edge N+2.
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] dx, input logic [7:0] dy);
    @(posedge iCLK_50); #1;
    bus.iPKT_VALID = 1'b1;
    bus.iPKT_B0    = b0;
    bus.iPKT_DX    = dx;
    bus.iPKT_DY    = dy;
    @(posedge iCLK_50); #1;
    bus.iPKT_VALID = 1'b0;
    @(posedge iCLK_50); #1;
  endtask

  task automatic test_reset;
    total++; if (oCUR_X !== 10'd320) begin bad++; $display("FAIL reset_x got=%0d want=320", oCUR_X); end
    total++; if (oCUR_Y !== 10'd240) begin bad++; $display("FAIL reset_y got=%0d want=240", oCUR_Y); end
    total++; if (bus.oPKT_READY !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.oPKT_READY); end
    total++; if (bus.oWR_REQ !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.oWR_REQ); end
    total++; if (oDROP_CNT !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", oDROP_CNT); end
    total++; if (oBUTTONS !== 3'b000) begin bad++; $display("FAIL reset_btn got=%b want=000", oBUTTONS); end
    total++; if (bus.oWR_X !== 10'd0 || bus.oWR_DATA !== 8'd0) begin bad++; $display("FAIL reset_wr got=%0d/%0d want=0/0", bus.oWR_X, bus.oWR_DATA); end
  endtask

  task automatic test_move;
    send_pkt(8'h08, 8'h05, 8'h03);
    total++; if (oCUR_X !== 10'd325 || oCUR_Y !== 10'd237) begin bad++; $display("FAIL move_xy got=(%0d,%0d) want=(325,237)", oCUR_X, oCUR_Y); end
    total++; if (bus.oWR_REQ !== 1'b0) begin bad++; $display("FAIL move_req got=%b want=0", bus.oWR_REQ); end
    total++; if (bus.oPKT_READY !== 1'b1) begin bad++; $display("FAIL move_ready got=%b want=1", bus.oPKT_READY); end
  endtask

  task automatic test_left_clamp;
    send_pkt(8'h18, 8'h1F, 8'h00);
    total++; if (oCUR_X !== 10'd100 || oCUR_Y !== 10'd237) begin bad++; $display("FAIL neg_move got=(%0d,%0d) want=(100,237)", oCUR_X, oCUR_Y); end
    iCOLOR = 8'hA5;
    send_pkt(8'h19, 8'h00, 8'h00);
    iCOLOR = 8'h3C;
    total++; if (oCUR_X !== 10'd0 || oCUR_Y !== 10'd237) begin bad++; $display("FAIL lclamp_xy got=(%0d,%0d) want=(0,237)", oCUR_X, oCUR_Y); end
    total++; if (bus.oWR_X !== 10'd0 || bus.oWR_Y !== 10'd237) begin bad++; $display("FAIL lclamp_wraddr got=(%0d,%0d) want=(0,237)", bus.oWR_X, bus.oWR_Y); end
    total++; if (bus.oWR_DATA !== 8'hA5) begin bad++; $display("FAIL lclamp_data got=%h want=a5", bus.oWR_DATA); end
    total++; if (oBUTTONS !== 3'b001) begin bad++; $display("FAIL lclamp_btn got=%b want=001", oBUTTONS); end
    for (int c = 1; c <= 4; c++) begin
      total++; if (bus.oWR_REQ !== 1'b1) begin bad++; $display("FAIL lclamp_req_hold cycle=%0d got=%b want=1", c, bus.oWR_REQ); end
      if (c == 4) bus.iWR_ACK = 1'b1;
      else begin @(posedge iCLK_50); #1; end
    end
    @(posedge iCLK_50); #1;
    bus.iWR_ACK = 1'b0;
    total++; if (bus.oWR_REQ !== 1'b0) begin bad++; $display("FAIL lclamp_req_fall got=%b want=0", bus.oWR_REQ); end
    total++; if (bus.oPKT_READY !== 1'b1) begin bad++; $display("FAIL lclamp_ready got=%b want=1", bus.oPKT_READY); end
  endtask

  task automatic test_right_overflow;
    send_pkt(8'h4A, 8'h7F, 8'h00);
    bus.iWR_ACK = 1'b1;
    total++; if (oCUR_X !== 10'd0 || oCUR_Y !== 10'd237) begin bad++; $display("FAIL rovf_xy got=(%0d,%0d) want=(0,237)", oCUR_X, oCUR_Y); end
    total++; if (bus.oWR_DATA !== 8'h00) begin bad++; $display("FAIL rovf_data got=%h want=00", bus.oWR_DATA); end
    total++; if (oBUTTONS !== 3'b010) begin bad++; $display("FAIL rovf_btn got=%b want=010", oBUTTONS); end
    total++; if (bus.oWR_REQ !== 1'b1) begin bad++; $display("FAIL rovf_req got=%b want=1", bus.oWR_REQ); end
    @(posedge iCLK_50); #1;
    bus.iWR_ACK = 1'b0;
    total++; if (bus.oWR_REQ !== 1'b0) begin bad++; $display("FAIL rovf_req_fall got=%b want=0", bus.oWR_REQ); end
  endtask

  task automatic test_back_to_back;
    @(posedge iCLK_50); #1;
    bus.iPKT_VALID = 1'b1; bus.iPKT_B0 = 8'h08; bus.iPKT_DX = 8'h0A; bus.iPKT_DY = 8'h00;
    @(posedge iCLK_50); #1;
    bus.iPKT_VALID = 1'b0;
    @(posedge iCLK_50); #1;
    bus.iPKT_VALID = 1'b1; bus.iPKT_B0 = 8'h08; bus.iPKT_DX = 8'h14; bus.iPKT_DY = 8'h05;
    @(posedge iCLK_50); #1;
    bus.iPKT_VALID = 1'b0;
    @(posedge iCLK_50); #1;
    total++; if (oCUR_X !== 10'd30 || oCUR_Y !== 10'd232) begin bad++; $display("FAIL b2b_xy got=(%0d,%0d) want=(30,232)", oCUR_X, oCUR_Y); end
    total++; if (oDROP_CNT !== 8'd0) begin bad++; $display("FAIL b2b_drop got=%0d want=0", oDROP_CNT); end
  endtask

  task automatic test_drop;
    send_pkt(8'h00, 8'h05, 8'h05);
    total++; if (oCUR_X !== 10'd30 || oCUR_Y !== 10'd232) begin bad++; $display("FAIL sync_xy got=(%0d,%0d) want=(30,232)", oCUR_X, oCUR_Y); end
    total++; if (oDROP_CNT !== 8'd1) begin bad++; $display("FAIL sync_drop got=%0d want=1", oDROP_CNT); end
    total++; if (bus.oWR_REQ !== 1'b0 || bus.oPKT_READY !== 1'b1) begin bad++; $display("FAIL sync_state got=req%b/rdy%b want=req0/rdy1", bus.oWR_REQ, bus.oPKT_READY); end
    send_pkt(8'h09, 8'h00, 8'h00);
    bus.iPKT_VALID = 1'b1; bus.iPKT_B0 = 8'h09; bus.iPKT_DX = 8'h05; bus.iPKT_DY = 8'h05;
    repeat (100) @(posedge iCLK_50);
    #1;
    total++; if (oDROP_CNT !== 8'd101) begin bad++; $display("FAIL busy_drop got=%0d want=101", oDROP_CNT); end
    repeat (200) @(posedge iCLK_50);
    #1;
    bus.iPKT_VALID = 1'b0;
    total++; if (oDROP_CNT !== 8'd255) begin bad++; $display("FAIL drop_sat got=%0d want=255", oDROP_CNT); end
    total++; if (oCUR_X !== 10'd30 || oCUR_Y !== 10'd232 || bus.oWR_X !== 10'd30) begin bad++; $display("FAIL req_stable got=(%0d,%0d) wrx=%0d want=(30,232) wrx=30", oCUR_X, oCUR_Y, bus.oWR_X); end
    total++; if (bus.oWR_REQ !== 1'b1) begin bad++; $display("FAIL req_held got=%b want=1", bus.oWR_REQ); end
    bus.iWR_ACK = 1'b1;
    @(posedge iCLK_50); #1;
    bus.iWR_ACK = 1'b0;
    total++; if (bus.oWR_REQ !== 1'b0) begin bad++; $display("FAIL drop_ack got=%b want=0", bus.oWR_REQ); end
  endtask

  task automatic test_edge_clamp;
    send_pkt(8'h08, 8'hFF, 8'hFF);
    total++; if (oCUR_X !== 10'd285 || oCUR_Y !== 10'd0) begin bad++; $display("FAIL top_clamp got=(%0d,%0d) want=(285,0)", oCUR_X, oCUR_Y); end
    send_pkt(8'h08, 8'hFF, 8'h00);
    send_pkt(8'h08, 8'hFF, 8'h00);
    total++; if (oCUR_X !== 10'd639 || oCUR_Y !== 10'd0) begin bad++; $display("FAIL right_clamp got=(%0d,%0d) want=(639,0)", oCUR_X, oCUR_Y); end
    send_pkt(8'h08, 8'h0A, 8'h0A);
    total++; if (oCUR_X !== 10'd639 || oCUR_Y !== 10'd0) begin bad++; $display("FAIL corner_hold got=(%0d,%0d) want=(639,0)", oCUR_X, oCUR_Y); end
    send_pkt(8'h18, 8'hFF, 8'h00);
    total++; if (oCUR_X !== 10'd638 || oCUR_Y !== 10'd0) begin bad++; $display("FAIL minus_one got=(%0d,%0d) want=(638,0)", oCUR_X, oCUR_Y); end
    send_pkt(8'h28, 8'h00, 8'h00);
    total++; if (oCUR_Y !== 10'd256) begin bad++; $display("FAIL down_256 got=%0d want=256", oCUR_Y); end
    send_pkt(8'h28, 8'h00, 8'h00);
    total++; if (oCUR_X !== 10'd638 || oCUR_Y !== 10'd479) begin bad++; $display("FAIL bottom_clamp got=(%0d,%0d) want=(638,479)", oCUR_X, oCUR_Y); end
    send_pkt(8'hA8, 8'h00, 8'h10);
    total++; if (oCUR_X !== 10'd638 || oCUR_Y !== 10'd479) begin bad++; $display("FAIL yovf_ignored got=(%0d,%0d) want=(638,479)", oCUR_X, oCUR_Y); end
  endtask

  task automatic test_reset_mid_req;
    send_pkt(8'h09, 8'h00, 8'h00);
    total++; if (bus.oWR_REQ !== 1'b1) begin bad++; $display("FAIL prerst_req got=%b want=1", bus.oWR_REQ); end
    #3;
    iRST_n = 1'b0;
    #2;
    total++; if (bus.oWR_REQ !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", bus.oWR_REQ); end
    total++; if (oCUR_X !== 10'd320 || oCUR_Y !== 10'd240) begin bad++; $display("FAIL rst_xy got=(%0d,%0d) want=(320,240)", oCUR_X, oCUR_Y); end
    total++; if (oDROP_CNT !== 8'd0 || oBUTTONS !== 3'b000) begin bad++; $display("FAIL rst_misc got=drop%0d/btn%b want=drop0/btn000", oDROP_CNT, oBUTTONS); end
    #5;
    iRST_n = 1'b1;
    @(posedge iCLK_50); #1;
    total++; if (bus.oPKT_READY !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.oPKT_READY); end
  endtask

  initial begin
    bus.iPKT_VALID = 1'b0;
    bus.iPKT_B0    = 8'h00;
    bus.iPKT_DX    = 8'h00;
    bus.iPKT_DY    = 8'h00;
    bus.iWR_ACK    = 1'b0;
    repeat (3) @(posedge iCLK_50);
    #1;
    iRST_n = 1'b1;
    @(posedge iCLK_50); #1;
    test_reset;
    test_move;
    test_left_clamp;
    test_right_overflow;
    test_back_to_back;
    test_drop;
    test_edge_clamp;
    test_reset_mid_req;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
